// File: rtl/plic_mt.sv
// Multi-target platform-level interrupt controller: per-source priority, per-target
// enable/threshold, claim/complete, registered arbitration. Optional edge mode: PLIC_EDGE_TRIGGER_EN.
module plic_mt #(
    parameter int N_SOURCES = 32,
    parameter int N_TARGETS = 2,
    parameter int PRIO_BITS = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_SOURCES-1:0] hw_interrupt_requests,
    input  logic [31:0]          addr,
    input  logic                 ren,
    input  logic                 wen,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic [N_TARGETS-1:0] irq
);
    localparam int ID_W = 5;
    localparam logic [N_SOURCES-1:0] SRC_MASK = {{(N_SOURCES-1){1'b1}}, 1'b0};

    logic [PRIO_BITS-1:0] prio       [N_SOURCES];
    logic [N_SOURCES-1:0] enable     [N_TARGETS];
    logic [PRIO_BITS-1:0] threshold  [N_TARGETS];
    logic [ID_W-1:0]      best_id    [N_TARGETS];
    logic [PRIO_BITS-1:0] best_prio  [N_TARGETS];
    logic [ID_W-1:0]      nxt_id     [N_TARGETS];
    logic [PRIO_BITS-1:0] nxt_prio   [N_TARGETS];
    logic [N_SOURCES-1:0] pending, in_service, req, claim_mask, done_mask;
    logic [ID_W-1:0]      claim_id;
    logic [31:0]          rd_val;

    // Bus: ren/wen are single-cycle strobes, never both high; no backpressure.
    // A write commits on the strobe edge, read data appears the cycle after ren.
    logic [9:0] a;
    logic [5:0] prio_idx;
    logic [3:0] tgt_idx;
    logic [1:0] tgt_reg;
    logic       prio_hit, tgt_hit;
    logic       unused_bits;

    assign a           = addr[9:0];
    assign prio_idx    = a[7:2];
    assign tgt_idx     = a[7:4];
    assign tgt_reg     = a[3:2];
    assign prio_hit    = (a[9:8] == 2'b00) && (prio_idx != 6'd0) && (int'(prio_idx) < N_SOURCES);
    assign tgt_hit     = (a[9:8] == 2'b10) && (int'(tgt_idx) < N_TARGETS);
    assign unused_bits = ^{addr[31:10], addr[1:0], wdata};

`ifdef PLIC_EDGE_TRIGGER_EN
    logic [N_SOURCES-1:0] trigger, hw_prev;

    always_ff @(posedge CLK) begin
        if (RST) begin
            trigger <= '0;
            hw_prev <= '0;
        end else begin
            hw_prev <= hw_interrupt_requests;
            if (wen && a == 10'h104)
                trigger <= wdata[N_SOURCES-1:0] & SRC_MASK;
        end
    end

    assign req = ((hw_interrupt_requests & ~trigger) |
                  (hw_interrupt_requests & ~hw_prev & trigger)) & SRC_MASK;
`else
    assign req = hw_interrupt_requests & SRC_MASK;
`endif

    // Ascending scan with strict '>' leaves ties with the lowest id.
    always_comb begin
        for (int t = 0; t < N_TARGETS; t++) begin
            nxt_id[t]   = '0;
            nxt_prio[t] = '0;
            for (int i = 1; i < N_SOURCES; i++) begin
                if (pending[i] && enable[t][i] && prio[i] > nxt_prio[t]) begin
                    nxt_id[t]   = ID_W'(i);
                    nxt_prio[t] = prio[i];
                end
            end
        end
    end

    always_comb begin
        claim_id   = '0;
        claim_mask = '0;
        done_mask  = '0;
        for (int t = 0; t < N_TARGETS; t++) begin
            if (ren && tgt_hit && tgt_reg == 2'd2 && tgt_idx == 4'(t))
                claim_id = best_id[t];
            if (wen && tgt_hit && tgt_reg == 2'd2 && tgt_idx == 4'(t)) begin
                for (int i = 1; i < N_SOURCES; i++)
                    if (wdata[4:0] == 5'(i) && enable[t][i])
                        done_mask[i] = 1'b1;
            end
        end
        for (int i = 1; i < N_SOURCES; i++)
            if (claim_id == ID_W'(i))
                claim_mask[i] = 1'b1;
    end

    always_comb begin
        rd_val = '0;
        if (prio_hit) begin
            for (int i = 1; i < N_SOURCES; i++)
                if (prio_idx == 6'(i))
                    rd_val[PRIO_BITS-1:0] = prio[i];
        end
        if (a == 10'h100)
            rd_val[N_SOURCES-1:0] = pending;
`ifdef PLIC_EDGE_TRIGGER_EN
        if (a == 10'h104)
            rd_val[N_SOURCES-1:0] = trigger;
`endif
        if (tgt_hit) begin
            for (int t = 0; t < N_TARGETS; t++) begin
                if (tgt_idx == 4'(t)) begin
                    case (tgt_reg)
                        2'd0:    rd_val[N_SOURCES-1:0] = enable[t];
                        2'd1:    rd_val[PRIO_BITS-1:0] = threshold[t];
                        2'd2:    rd_val[ID_W-1:0]      = best_id[t];
                        default: rd_val                = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rdata      <= '0;
            pending    <= '0;
            in_service <= '0;
            for (int i = 0; i < N_SOURCES; i++)
                prio[i] <= '0;
            for (int t = 0; t < N_TARGETS; t++) begin
                enable[t]    <= '0;
                threshold[t] <= '0;
                best_id[t]   <= '0;
                best_prio[t] <= '0;
            end
        end else begin
            if (ren)
                rdata <= rd_val;
            // A claim on the same edge as a gateway set wins.
            pending    <= (pending | (req & ~in_service)) & ~claim_mask;
            in_service <= (in_service | claim_mask) & ~done_mask;
            if (wen && prio_hit) begin
                for (int i = 1; i < N_SOURCES; i++)
                    if (prio_idx == 6'(i))
                        prio[i] <= wdata[PRIO_BITS-1:0];
            end
            for (int t = 0; t < N_TARGETS; t++) begin
                if (wen && tgt_hit && tgt_idx == 4'(t)) begin
                    if (tgt_reg == 2'd0)
                        enable[t] <= wdata[N_SOURCES-1:0] & SRC_MASK;
                    if (tgt_reg == 2'd1)
                        threshold[t] <= wdata[PRIO_BITS-1:0];
                end
                // Drop the just-claimed id everywhere so no target raises a stale irq.
                if (claim_id != '0 && (best_id[t] == claim_id || nxt_id[t] == claim_id)) begin
                    best_id[t]   <= '0;
                    best_prio[t] <= '0;
                end else begin
                    best_id[t]   <= nxt_id[t];
                    best_prio[t] <= nxt_prio[t];
                end
            end
        end
    end

    always_comb begin
        for (int t = 0; t < N_TARGETS; t++)
            irq[t] = best_prio[t] > threshold[t];
    end

endmodule

// File: tb/tb_plic_mt.sv
// Directed self-checking bench for plic_mt (default 32 sources, 2 targets, 3-bit priority).
module tb_plic_mt;
    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] hw;
    logic [31:0] addr;
    logic        ren;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  irq;

    int pass_cnt  = 0;
    int check_cnt = 0;

    plic_mt #(.N_SOURCES(32), .N_TARGETS(2), .PRIO_BITS(3)) dut (
        .CLK                   (CLK),
        .RST                   (RST),
        .hw_interrupt_requests (hw),
        .addr                  (addr),
        .ren                   (ren),
        .wen                   (wen),
        .wdata                 (wdata),
        .rdata                 (rdata),
        .irq                   (irq)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            pass_cnt++;
    endtask

    // All drivers start and end on a falling edge.
    task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wen   = 1'b1;
        @(negedge CLK);
        wen   = 1'b0;
    endtask

    task automatic reg_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        ren  = 1'b1;
        @(negedge CLK);
        ren  = 1'b0;
        d    = rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        reg_read(a, d);
        check(tag, d, exp);
    endtask

    initial begin
        RST   = 1'b1;
        hw    = '0;
        addr  = '0;
        ren   = 1'b0;
        wen   = 1'b0;
        wdata = '0;
        idle(2);
        RST = 1'b0;

        // Reset state of every mapped register
        check("rst_rdata", rdata, 32'h0);
        check("rst_irq", {30'h0, irq}, 32'h0);
        for (int i = 0; i < 32; i++)
            read_check($sformatf("rst_prio%0d", i), 32'(4 * i), 32'h0);
        read_check("rst_pending", 32'h100, 32'h0);
        read_check("rst_trigger", 32'h104, 32'h0);
        for (int t = 0; t < 2; t++) begin
            read_check($sformatf("rst_en%0d", t),    32'h200 + 32'(16 * t), 32'h0);
            read_check($sformatf("rst_thr%0d", t),   32'h204 + 32'(16 * t), 32'h0);
            read_check($sformatf("rst_claim%0d", t), 32'h208 + 32'(16 * t), 32'h0);
        end

        // Source 5 level, two-cycle latency to irq[0]
        reg_write(32'h014, 32'd3);
        reg_write(32'h200, 32'h20);
        reg_write(32'h204, 32'd1);
        read_check("prio5_rb", 32'h014, 32'd3);
        hw[5] = 1'b1;
        idle(1);
        check("irq0_lat1", {30'h0, irq}, 32'h0);
        idle(1);
        check("irq0_lat2", {30'h0, irq}, 32'h1);

        // Claim 5 while source still high
        read_check("claim5", 32'h208, 32'd5);
        check("irq0_after_claim", {30'h0, irq}, 32'h0);
        read_check("pend_after_claim", 32'h100, 32'h0);
        reg_write(32'h208, 32'd9);
        idle(1);
        read_check("pend_after_cmp9", 32'h100, 32'h0);
        reg_write(32'h208, 32'd5);
        idle(1);
        read_check("pend_after_cmp5", 32'h100, 32'h20);
        check("irq0_repend", {30'h0, irq}, 32'h1);
        read_check("claim5_again", 32'h208, 32'd5);
        hw[5] = 1'b0;
        reg_write(32'h208, 32'd5);

        // Tie on priority 2 between 3 and 7; target 1 watches 7 only
        reg_write(32'h00C, 32'd2);
        reg_write(32'h01C, 32'd2);
        reg_write(32'h200, 32'h88);
        reg_write(32'h210, 32'h80);
        hw[3] = 1'b1;
        hw[7] = 1'b1;
        idle(3);
        check("irq_both", {30'h0, irq}, 32'h3);
        read_check("claim_tie", 32'h208, 32'd3);
        reg_write(32'h208, 32'd3);
        idle(3);
        check("irq1_src7", {30'h0, irq}, 32'h3);
        reg_write(32'h01C, 32'd4);
        idle(2);
        read_check("claim_prio7", 32'h208, 32'd7);
        check("irq1_forced_off", {30'h0, irq[1]}, 32'h0);
        read_check("claim_t1_empty", 32'h218, 32'h0);
        hw[7] = 1'b0;
        reg_write(32'h208, 32'd7);
        read_check("claim3_left", 32'h208, 32'd3);
        hw[3] = 1'b0;
        reg_write(32'h208, 32'd3);
        idle(2);
        check("irq_quiet", {30'h0, irq}, 32'h0);

        // Threshold equal to priority masks irq but claim still works
        reg_write(32'h200, 32'h20);
        reg_write(32'h204, 32'd3);
        hw[5] = 1'b1;
        idle(3);
        check("irq0_thr_mask", {30'h0, irq}, 32'h0);
        read_check("claim_masked", 32'h208, 32'd5);
        hw[5] = 1'b0;
        reg_write(32'h208, 32'd5);
        idle(2);
        read_check("pend_clean", 32'h100, 32'h0);

        // Address map corners
        reg_write(32'h000, 32'd7);
        read_check("prio0_ro", 32'h000, 32'h0);
        reg_write(32'h220, 32'hFF);
        read_check("tgt2_unmapped", 32'h220, 32'h0);
        read_check("unmapped_300", 32'h300, 32'h0);
        reg_write(32'h200, 32'hFFFFFFFF);
        read_check("en0_bit0", 32'h200, 32'hFFFFFFFE);
        read_check("thr0_rb", 32'h204, 32'd3);
        reg_write(32'h214, 32'd6);
        read_check("thr1_rb", 32'h214, 32'd6);

`ifdef PLIC_EDGE_TRIGGER_EN
        reg_write(32'h204, 32'd0);
        reg_write(32'h200, 32'h4);
        reg_write(32'h104, 32'h5);
        read_check("trig_rb", 32'h104, 32'h4);
        reg_write(32'h008, 32'd1);
        hw[2] = 1'b1;
        idle(1);
        hw[2] = 1'b0;
        idle(1);
        read_check("edge_pend", 32'h100, 32'h4);
        read_check("edge_claim", 32'h208, 32'd2);
        hw[2] = 1'b1;
        idle(1);
        hw[2] = 1'b0;
        idle(1);
        read_check("edge_dropped", 32'h100, 32'h0);
        reg_write(32'h208, 32'd2);
        idle(2);
        read_check("edge_no_repend", 32'h100, 32'h0);
`else
        reg_write(32'h104, 32'hFFFFFFFF);
        read_check("trig_absent", 32'h104, 32'h0);
`endif

        // Reset mid-operation clears in-flight state
        reg_write(32'h204, 32'd0);
        reg_write(32'h200, 32'h20);
        hw[5] = 1'b1;
        idle(3);
        check("irq_before_rst", {30'h0, irq}, 32'h1);
        RST = 1'b1;
        idle(1);
        RST = 1'b0;
        check("irq_after_rst", {30'h0, irq}, 32'h0);
        read_check("en0_after_rst", 32'h200, 32'h0);
        hw = '0;

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/plic_mt.md
Name: plic_mt

Overview:
- Parametrised multi-target platform-level interrupt controller; successor to the single-target interrupt controller.
- Sits between peripheral interrupt lines and N_TARGETS cores/harts on the peripheral register bus.
- Adds per-source priority, per-target enable and threshold, claim/complete handshake, and a registered arbitration stage.

Parameters:
- N_SOURCES, 32, source count incl. reserved source 0; legal 2..32.
- N_TARGETS, 2, interrupt targets; legal 1..4.
- PRIO_BITS, 3, priority width; priority 0 = never interrupt.

Ports:
- CLK  input  1  system clock
- RST  input  1  synchronous active-high reset
- hw_interrupt_requests  input  N_SOURCES  raw source lines; bit 0 ignored
- addr  input  32  byte address; only addr[9:0] decoded, addr[1:0] ignored
- ren  input  1  single-cycle read strobe
- wen  input  1  single-cycle write strobe; ren and wen never both high
- wdata  input  32  write data
- rdata  output  32  read data, registered
- irq  output  N_TARGETS  per-target interrupt request

Behaviour:
- Interface: one clock, CLK; reset RST synchronous, active-high, sampled on CLK rising edge.
- Reset values: rdata=0, irq=0; all priority, enable, threshold, pending, in_service and arbitration registers = 0.
- Register map (word offsets):
  - 0x000+4*i: priority[i], PRIO_BITS, RW, i=1..N_SOURCES-1; i=0 reads 0, writes ignored.
  - 0x100: pending[N_SOURCES-1:0], RO.
  - 0x200+0x10*t: enable[t], RW; bit 0 forced 0.
  - 0x204+0x10*t: threshold[t], PRIO_BITS, RW.
  - 0x208+0x10*t: claim (read) / complete (write).
  - Unmapped addresses, or t >= N_TARGETS: read 0, writes ignored.
- Reads: rdata loaded the cycle after ren and held until the next ren. Writes take effect on the same edge as wen.
- Gateway, per source i (level mode):
  - pending[i] sets when hw_interrupt_requests[i]=1, pending[i]=0 and in_service[i]=0.
  - pending[i] clears only by a claim.
- Arbitration, per target t, registered every cycle:
  - Candidates: sources with pending=1, enable[t]=1 and priority>0.
  - best_id[t]/best_prio[t] = highest priority; ties go to the lowest id; no candidate gives 0/0.
  - irq[t] = (best_prio[t] > threshold[t]), combinational from the registers.
- Latency: source rises at edge n -> pending at n+1 -> best_id/irq valid after n+2.
- Claim (ren to 0x208+0x10*t):
  - rdata = best_id[t] as registered in the ren cycle.
  - If nonzero: pending[id] cleared, in_service[id] set.
  - Every target whose best_id equals id has best forced to 0 on the same edge, so there is no stale irq.
  - Claim with best_id=0 returns 0 and has no side effects.
- Complete (wen to claim address):
  - id = wdata[4:0]; clears in_service[id] only if id<N_SOURCES, id!=0 and enable[t][id]=1. Otherwise ignored.
  - A still-high level source re-pends the cycle after complete.
- Simultaneous events: claim and gateway set on the same source in one cycle: claim wins (pending=0, in_service=1).
- Priority or enable changes affect arbitration from the next cycle; in_service is unaffected.
- Reset mid-operation clears all state, including in_service; outstanding claims are lost.

Optional Feature:
- Macro PLIC_EDGE_TRIGGER_EN.
- Defined:
  - Adds RW register 0x104, trigger[N_SOURCES-1:0], bit 0 forced 0; 1 = edge mode.
  - Edge-mode source sets pending on a rising edge (current=1, previous-cycle sample=0) when pending=0 and in_service=0. Edges arriving otherwise are dropped.
  - Sample register resets to 0.
- Undefined: 0x104 reads 0, writes ignored; all sources level-triggered.

Test Plan:
- Reset: assert RST 2 cycles, then read every mapped register -> all 0; irq=0.
- Source 5 high, priority[5]=3, enable[0]=0x20, threshold[0]=1 -> irq[0]=1 two cycles after source rise; irq[1]=0.
- Sources 3 and 7 both priority 2 -> claim returns 3. Priority[7]=4 -> next claim returns 7.
- Threshold[0]=3 with source priority 3 -> irq[0]=0. Claim still returns the source id.
- Claim id 5 with source 5 still high -> pending[5]=0, irq drops next cycle.
  - Complete wdata=5 -> pending[5]=1 next cycle.
  - Complete wdata=9 (not enabled) -> no change.
- PLIC_EDGE_TRIGGER_EN: trigger[2]=1, one-cycle pulse on source 2 -> pending[2]=1. A second pulse while in_service -> dropped; after complete, no re-pend.
